// File: rtl/param_memory.sv
// -----------------------------------------------------------------------------
// param_memory
//
// Parametrised single-port synchronous word memory shared by the pipeline
// stages. It serves as the instruction memory (write side tied off) or as the
// data memory of the three-stage pipeline.
//
// After reset a hardware init engine walks every word and writes INIT_VAL.
// Requests are refused while it runs. Once it finishes, the block accepts one
// request per cycle over a valid/ready handshake:
//   - writes update the selected byte lanes at the accepting edge;
//   - reads return data one cycle later (registered read port);
//   - out-of-range addresses leave memory untouched and pulse err. An
//     out-of-range read still completes, with zero data.
//
// Parameters:
//   DATA_W    data word width in bits (multiple of 8)
//   ADDR_W    request word-address width in bits
//   DEPTH     number of implemented words (2 .. 2**ADDR_W)
//   INIT_VAL  value written to every word by the init engine
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous reset, active low
//   req_valid  request present this cycle
//   req_ready  block accepts a request this cycle
//   req_wen    1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   req_be     byte-lane write enables, bit i covers bits [8i+7:8i]
//   rd_valid   rd_data carries a read result this cycle
//   rd_data    read data, holds its value between reads
//   err        one-cycle pulse: the accepted request was out of range
//   init_busy  init engine is running
// -----------------------------------------------------------------------------
module param_memory #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  err,
    output logic                  init_busy
);

    localparam int LANES = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH may equal 2**ADDR_W, which does not fit in ADDR_W bits, so the
    // range check is done one bit wider than the address.
    localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  init_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              addr_ok;
    logic [IDX_W-1:0]  req_idx;

    // req_ready is a registered copy of "state is READY", so acceptance is
    // known at the start of the cycle and needs no combinational path back
    // from req_valid.
    assign accept  = req_valid & req_ready;

    // Full-width unsigned comparison. Addresses never wrap modulo DEPTH.
    assign addr_ok = {1'b0, req_addr} < DEPTH_EXT;

    // The low bits are only used as an index when addr_ok is true, so the
    // truncation never aliases a legal word.
    assign req_idx = req_addr[IDX_W-1:0];

    // Control FSM and registered outputs. Reset wins over everything: it
    // restarts the init count, drops any read that would complete at this
    // edge, and clears rd_data. rd_valid and err default low every cycle, so
    // each acts as a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            req_ready <= 1'b0;
            init_busy <= 1'b1;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            err       <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            err      <= 1'b0;
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + IDX_W'(1);
                    if (init_cnt == LAST_IDX) begin
                        state     <= ST_READY;
                        init_cnt  <= '0;
                        req_ready <= 1'b1;
                        init_busy <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (accept) begin
                        if (!addr_ok) begin
                            err <= 1'b1;
                        end
                        if (!req_wen) begin
                            rd_valid <= 1'b1;
                            rd_data  <= addr_ok ? mem[req_idx] : '0;
                        end
                    end
                end
                default: begin
                    state     <= ST_INIT;
                    init_cnt  <= '0;
                    req_ready <= 1'b0;
                    init_busy <= 1'b1;
                end
            endcase
        end
    end

    // Storage array. It has no reset of its own; the init engine fills it.
    // Writes are gated by rst so that a reset edge never disturbs contents.
    // A read in the cycle right after a write to the same word sees the new
    // data, because the write has already landed at the previous edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == ST_INIT) begin
                mem[init_cnt] <= INIT_VAL;
            end else if (accept && req_wen && addr_ok) begin
                for (int i = 0; i < LANES; i++) begin
                    if (req_be[i]) begin
                        mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_param_memory.sv
// -----------------------------------------------------------------------------
// tb_param_memory
//
// Self-checking bench for param_memory with DEPTH = 8 and INIT_VAL =
// 32'hDEADBEEF. A word-array reference model predicts read data, rd_valid and
// err for every request. Each scenario task drives requests and compares the
// outputs it sees against the model and against known constants.
// -----------------------------------------------------------------------------
module tb_param_memory;

    localparam int          DATA_W   = 32;
    localparam int          ADDR_W   = 32;
    localparam int          DEPTH    = 8;
    localparam logic [31:0] INIT_VAL = 32'hDEADBEEF;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        err;
    logic        init_busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] model_mem [DEPTH];
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_err;

    param_memory #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .INIT_VAL (INIT_VAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .err       (err),
        .init_busy (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something hangs
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Memory after init holds INIT_VAL everywhere; rd_data restarts at 0
    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT_VAL;
        exp_valid = 1'b0;
        exp_data  = 32'h0;
        exp_err   = 1'b0;
    endtask

    // One request cycle: drive inputs at the falling edge, let the rising
    // edge take them, and return at the next falling edge with the model
    // predicting what the outputs show now.
    task automatic step(input logic v, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        req_valid = v;
        req_wen   = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (v) begin
            if (a < 32'(DEPTH)) begin
                if (w) begin
                    for (int i = 0; i < 4; i++)
                        if (be[i]) model_mem[a[2:0]][8*i +: 8] = d[8*i +: 8];
                end else begin
                    exp_valid = 1'b1;
                    exp_data  = model_mem[a[2:0]];
                end
            end else begin
                exp_err = 1'b1;
                if (!w) begin
                    exp_valid = 1'b1;
                    exp_data  = 32'h0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_wen   = 1'b0;
    endtask

    // Count falling edges with init_busy high, starting at the current one,
    // and note any cycle where req_ready was high during init. Bounded.
    task automatic wait_init(output int busy_cycles, output int ready_viol);
        busy_cycles = 0;
        ready_viol  = 0;
        for (int g = 0; g < 64 && init_busy === 1'b1; g++) begin
            busy_cycles++;
            if (req_ready !== 1'b0) ready_viol++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int busy, viol;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (init_busy !== 1'b1 || req_ready !== 1'b0 || rd_valid !== 1'b0 ||
            rd_data !== 32'h0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: busy=%b ready=%b rd_valid=%b rd_data=%h err=%b expected 1 0 0 00000000 0",
                     init_busy, req_ready, rd_valid, rd_data, err);
        end
        rst = 1'b1;
        // A write request during init must be ignored
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h0;
        req_wdata = 32'h0; req_be = 4'hF;
        wait_init(busy, viol);
        req_valid = 1'b0; req_wen = 1'b0;
        model_reset();
        checks++;
        if (busy !== 8) begin
            errors++;
            $display("[TB] FAIL init_length: got %0d cycles expected 8", busy);
        end
        checks++;
        if (viol !== 0 || req_ready !== 1'b1 || init_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL init_handshake: ready_viol=%0d ready=%b busy=%b expected 0 1 0",
                     viol, req_ready, init_busy);
        end
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b1, 1'b0, 32'(a), 32'h0, 4'h0);
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 32'hDEADBEEF || err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL init_value[%0d]: rd_valid=%b rd_data=%h err=%b expected 1 deadbeef 0",
                         a, rd_valid, rd_data, err);
            end
        end
    endtask

    task automatic test_write_read();
        step(1'b1, 1'b1, 32'd3, 32'h05031000, 4'hF);
        checks++;
        if (rd_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_resp: rd_valid=%b err=%b expected 0 0", rd_valid, err);
        end
        step(1'b1, 1'b0, 32'd3, 32'h0, 4'h0);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h05031000 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_read: rd_valid=%b rd_data=%h err=%b expected 1 05031000 0",
                     rd_valid, rd_data, err);
        end
    endtask

    task automatic test_byte_enable();
        step(1'b1, 1'b1, 32'd5, 32'h11223344, 4'hF);
        step(1'b1, 1'b1, 32'd5, 32'hAABBCCDD, 4'b0101);
        step(1'b1, 1'b0, 32'd5, 32'h0, 4'h0);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h11BB33DD) begin
            errors++;
            $display("[TB] FAIL byte_enable: rd_valid=%b rd_data=%h expected 1 11bb33dd",
                     rd_valid, rd_data);
        end
        // be = 0 is a no-op
        step(1'b1, 1'b1, 32'd5, 32'h99999999, 4'h0);
        step(1'b1, 1'b0, 32'd5, 32'h0, 4'h0);
        checks++;
        if (rd_data !== 32'h11BB33DD) begin
            errors++;
            $display("[TB] FAIL be_zero: rd_data=%h expected 11bb33dd", rd_data);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] held;
        held = rd_data;
        step(1'b1, 1'b1, 32'd8, 32'hFFFFFFFF, 4'hF);
        checks++;
        if (err !== 1'b1 || rd_valid !== 1'b0 || rd_data !== held) begin
            errors++;
            $display("[TB] FAIL oor_write: err=%b rd_valid=%b rd_data=%h expected 1 0 %h",
                     err, rd_valid, rd_data, held);
        end
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_pulse: err=%b expected 0", err);
        end
        step(1'b1, 1'b0, 32'd0, 32'h0, 4'h0);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL oor_mem0: rd_valid=%b rd_data=%h expected 1 deadbeef", rd_valid, rd_data);
        end
        step(1'b1, 1'b0, 32'h00000108, 32'h0, 4'h0);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h0 || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL oor_read: rd_valid=%b rd_data=%h err=%b expected 1 00000000 1",
                     rd_valid, rd_data, err);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] wval;
        for (int a = 0; a < 3; a++) begin
            step(1'b1, 1'b0, 32'(a), 32'h0, 4'h0);
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp_data) begin
                errors++;
                $display("[TB] FAIL stream[%0d]: rd_valid=%b rd_data=%h expected 1 %h",
                         a, rd_valid, rd_data, exp_data);
            end
        end
        wval = $urandom;
        step(1'b1, 1'b1, 32'd1, wval, 4'hF);
        step(1'b1, 1'b0, 32'd1, 32'h0, 4'h0);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== wval) begin
            errors++;
            $display("[TB] FAIL raw_hazard: rd_valid=%b rd_data=%h expected 1 %h", rd_valid, rd_data, wval);
        end
    endtask

    task automatic test_random();
        logic        v, w;
        logic [31:0] a;
        for (int n = 0; n < 300; n++) begin
            v = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 5))
                0:       a = $urandom;
                1:       a = 32'(DEPTH) + 32'($urandom_range(0, 3));
                default: a = 32'($urandom_range(0, DEPTH - 1));
            endcase
            step(v, w, a, $urandom, 4'($urandom_range(0, 15)));
            checks++;
            if (rd_valid !== exp_valid || rd_data !== exp_data || err !== exp_err) begin
                errors++;
                $display("[TB] FAIL random[%0d] addr=%h wen=%b valid=%b: got rd_valid=%b rd_data=%h err=%b expected %b %h %b",
                         n, a, w, v, rd_valid, rd_data, err, exp_valid, exp_data, exp_err);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int busy, viol;
        step(1'b1, 1'b0, 32'd2, 32'h0, 4'h0);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp_data) begin
            errors++;
            $display("[TB] FAIL pre_reset_read: rd_valid=%b rd_data=%h expected 1 %h", rd_valid, rd_data, exp_data);
        end
        // Next read collides with reset and must not complete
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'd3;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'h0 || init_busy !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_read: rd_valid=%b rd_data=%h busy=%b ready=%b expected 0 00000000 1 0",
                     rd_valid, rd_data, init_busy, req_ready);
        end
        rst = 1'b1;
        wait_init(busy, viol);
        model_reset();
        checks++;
        if (busy !== 8 || viol !== 0) begin
            errors++;
            $display("[TB] FAIL reinit_after_read: busy=%0d ready_viol=%0d expected 8 0", busy, viol);
        end
    endtask

    task automatic test_reset_mid_init();
        int busy, viol;
        step(1'b1, 1'b1, 32'd6, 32'h12345678, 4'hF);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (init_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_init_busy: busy=%b expected 1", init_busy);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_init(busy, viol);
        model_reset();
        checks++;
        if (busy !== 8 || viol !== 0) begin
            errors++;
            $display("[TB] FAIL restart_init: busy=%0d ready_viol=%0d expected 8 0", busy, viol);
        end
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b1, 1'b0, 32'(a), 32'h0, 4'h0);
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 32'hDEADBEEF) begin
                errors++;
                $display("[TB] FAIL reinit_value[%0d]: rd_valid=%b rd_data=%h expected 1 deadbeef",
                         a, rd_valid, rd_data);
            end
        end
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_be    = 4'h0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_write_read();
        test_byte_enable();
        test_out_of_range();
        test_streaming();
        test_random();
        test_reset_mid_read();
        test_reset_mid_init();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_memory.md
Name: param_memory

Overview:
- Parametrised single-port synchronous memory; next generation of the shared instruction/data memory used by the pipeline stages.
- Adds a configurable width and depth, a valid/ready request handshake, a registered 1-cycle read, byte-lane write enables, and an address-range error flag.
- Adds a hardware init engine that fills every word with INIT_VAL after reset.
- Serves as the IMEM (writes tied off) or the DMEM of the three-stage pipeline.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- ADDR_W, 32, request address width in bits (word address).
- DEPTH, 256, number of words implemented; must be ≤ 2^ADDR_W and ≥ 2.
- INIT_VAL, 0, value written to every word by the init engine.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low; sampled on posedge clk.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  block accepts a request this cycle.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte-lane write enables; bit i covers bits [8i+7:8i].
- rd_valid  out  1  rd_data is valid this cycle.
- rd_data  out  DATA_W  read data.
- err  out  1  one-cycle pulse: the accepted request had an out-of-range address.
- init_busy  out  1  init engine is running.

Behaviour:
- Reset (rst = 0 at posedge):
  - Enters state INIT with init_cnt = 0.
  - req_ready = 0, rd_valid = 0, rd_data = 0, err = 0, init_busy = 1.
  - Reset overrides any activity in progress, including an in-flight read (its rd_valid is suppressed) and an init already running (the count restarts at 0).
- State INIT:
  - Each cycle with rst = 1, writes INIT_VAL to mem[init_cnt] and increments init_cnt.
  - The write at init_cnt = DEPTH-1 is the last; the next state is READY.
  - Takes exactly DEPTH cycles after rst is released.
  - init_busy = 1 and req_ready = 0 throughout; req_valid is ignored.
- State READY: init_busy = 0 and req_ready = 1 every cycle. Acceptance is req_valid & req_ready.
- Accepted write, in range (req_addr < DEPTH):
  - At the same posedge, each lane i with req_be[i] = 1 takes req_wdata lane i. Lanes with req_be[i] = 0 keep their value.
  - req_be = 0 is a legal no-op.
  - rd_valid stays 0.
- Accepted read, in range: at the next posedge rd_data = mem[req_addr] and rd_valid = 1 for one cycle. Latency is exactly 1.
- Out-of-range address (req_addr ≥ DEPTH), read or write:
  - Memory is unchanged.
  - err = 1 for one cycle on the next posedge.
  - A read also gives rd_valid = 1 with rd_data = 0.
- Back-to-back reads: one per cycle, each returning data on the following cycle; no bubbles.
- Read after write to the same address in consecutive cycles: the read returns the newly written data.
- rd_data holds its last value while rd_valid = 0. It returns to 0 only on reset.
- Address comparison is unsigned at the full ADDR_W width; there is no wrap-around or truncation modulo DEPTH.

Test Plan:
- Reset and init, DEPTH = 8, INIT_VAL = 32'hDEADBEEF: hold rst = 0 for 2 cycles, then release.
  - init_busy = 1 and req_ready = 0 for exactly 8 cycles, then 0/1.
  - Reading addresses 0..7 returns 32'hDEADBEEF each.
- Write then read: write addr 3 = 32'h05031000 with be = 4'hF, then read addr 3.
  - rd_valid = 1 one cycle later with rd_data = 32'h05031000.
  - err = 0 throughout.
- Byte enables: addr 5 holds 32'h11223344; write 32'hAABBCCDD with be = 4'b0101.
  - A read of addr 5 returns 32'h11BB33DD.
- Out of range, DEPTH = 8:
  - Write addr 8 with 32'hFFFFFFFF: err pulses for 1 cycle; mem[0] is unchanged.
  - Read addr 32'h00000108: rd_valid = 1, rd_data = 0, err = 1.
- Streaming: read addresses 0, 1, 2 on consecutive cycles.
  - rd_valid is high for 3 consecutive cycles with the data in order.
  - Then write addr 1 and read addr 1 on the next cycle: the read returns the new value.
- Reset mid-operation:
  - Assert rst = 0 in the cycle after a read is accepted: rd_valid stays 0, and INIT restarts.
  - Assert rst = 0 while init_cnt = 4: after release, init_busy lasts a full DEPTH cycles again.
